// File: rtl/stp_pattern_det.sv
// Serial-to-parallel shift register with a masked pattern matcher, a word
// framing strobe and a saturating match counter. All outputs are registered.
module stp_pattern_det #(
  parameter int BIT_WIDTH = 4,
  parameter int CNT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 ser_in,
  input  logic                 clear,
  input  logic [BIT_WIDTH-1:0] pattern,
  input  logic [BIT_WIDTH-1:0] mask,
  output logic [BIT_WIDTH-1:0] par_out,
  output logic                 primed,
  output logic                 match,
  output logic                 match_pulse,
  output logic                 word_valid,
  output logic [CNT_WIDTH-1:0] match_cnt
);

  localparam int FW = $clog2(BIT_WIDTH + 1);
  localparam int RW = $clog2(BIT_WIDTH);
  localparam logic [FW-1:0] FILL_MAX   = FW'(BIT_WIDTH);
  localparam logic [RW-1:0] FRAME_LAST = RW'(BIT_WIDTH - 1);

  logic [BIT_WIDTH-1:0] par_q, par_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [RW-1:0]        frame_q, frame_d;
  logic                 primed_q, primed_d;
  logic                 match_q, match_d;
  logic                 pulse_q, pulse_d;
  logic                 wv_q, wv_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hit;

  always_comb begin
    par_d    = par_q;
    fill_d   = fill_q;
    frame_d  = frame_q;
    primed_d = primed_q;
    match_d  = match_q;
    pulse_d  = 1'b0;
    wv_d     = 1'b0;
    cnt_d    = cnt_q;
    hit      = 1'b0;
    if (clear) begin
      par_d    = '0;
      fill_d   = '0;
      frame_d  = '0;
      primed_d = 1'b0;
      match_d  = 1'b0;
      cnt_d    = '0;
    end else if (shift_en) begin
      if (MSB_FIRST) par_d = {par_q[BIT_WIDTH-2:0], ser_in};
      else           par_d = {ser_in, par_q[BIT_WIDTH-1:1]};
      fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
      primed_d = (fill_d == FILL_MAX);
      // Compare against the post-shift word so the result has no extra latency.
      hit      = primed_d && (((par_d ^ pattern) & mask) == '0);
      match_d  = hit;
      pulse_d  = hit;
      if (hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
      wv_d     = (frame_q == FRAME_LAST);
      frame_d  = wv_d ? '0 : frame_q + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q    <= '0;
      fill_q   <= '0;
      frame_q  <= '0;
      primed_q <= 1'b0;
      match_q  <= 1'b0;
      pulse_q  <= 1'b0;
      wv_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      par_q    <= par_d;
      fill_q   <= fill_d;
      frame_q  <= frame_d;
      primed_q <= primed_d;
      match_q  <= match_d;
      pulse_q  <= pulse_d;
      wv_q     <= wv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign par_out     = par_q;
  assign primed      = primed_q;
  assign match       = match_q;
  assign match_pulse = pulse_q;
  assign word_valid  = wv_q;
  assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_stp_pattern_det.sv
// Drives three differently configured stp_pattern_det instances with one
// shared stimulus stream and checks them against a bit-history model.
module tb_stp_pattern_det;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_en = 1'b0;
  logic       ser_in = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] pattern_r = '0;
  logic [4:0] mask_r = '0;

  logic [3:0] par_a, par_b;
  logic [4:0] par_c;
  logic       primed_a, primed_b, primed_c;
  logic       match_a, match_b, match_c;
  logic       pulse_a, pulse_b, pulse_c;
  logic       wv_a, wv_b, wv_c;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [2:0] cnt_c;

  int n_chk = 0;
  int n_pass = 0;

  // Model state: every bit shifted since the last rst/clear, plus per-instance results.
  logic       hist[$];
  int         hits[3];
  logic       em[3];
  logic       ep[3];
  logic       ewv[3];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  stp_pattern_det #(.BIT_WIDTH(4), .CNT_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .shift_en(shift_en), .ser_in(ser_in), .clear(clear),
    .pattern(pattern_r[3:0]), .mask(mask_r[3:0]), .par_out(par_a), .primed(primed_a),
    .match(match_a), .match_pulse(pulse_a), .word_valid(wv_a), .match_cnt(cnt_a));

  stp_pattern_det #(.BIT_WIDTH(4), .CNT_WIDTH(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .shift_en(shift_en), .ser_in(ser_in), .clear(clear),
    .pattern(pattern_r[3:0]), .mask(mask_r[3:0]), .par_out(par_b), .primed(primed_b),
    .match(match_b), .match_pulse(pulse_b), .word_valid(wv_b), .match_cnt(cnt_b));

  stp_pattern_det #(.BIT_WIDTH(5), .CNT_WIDTH(3), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst(rst), .shift_en(shift_en), .ser_in(ser_in), .clear(clear),
    .pattern(pattern_r), .mask(mask_r), .par_out(par_c), .primed(primed_c),
    .match(match_c), .match_pulse(pulse_c), .word_valid(wv_c), .match_cnt(cnt_c));

  function automatic int w_of(input int d);
    return (d == 2) ? 5 : 4;
  endfunction

  function automatic int cap_of(input int d);
    return (d == 0) ? 255 : ((d == 1) ? 3 : 7);
  endfunction

  function automatic bit msb_of(input int d);
    return (d != 2);
  endfunction

  // Bit shifted i shifts ago sits at position i (MSB-first) or W-1-i (LSB-first).
  function automatic logic [7:0] par_of(input int d);
    logic [7:0] p;
    int n;
    p = '0;
    n = hist.size();
    for (int i = 0; i < w_of(d); i++) begin
      if (i < n) begin
        if (msb_of(d)) p[i] = hist[n-1-i];
        else           p[w_of(d)-1-i] = hist[n-1-i];
      end
    end
    return p;
  endfunction

  function automatic logic hit_of(input int d);
    logic [7:0] wm;
    wm = 8'((1 << w_of(d)) - 1);
    return (hist.size() >= w_of(d)) &&
           ((((par_of(d) ^ {3'b0, pattern_r}) & {3'b0, mask_r}) & wm) == 8'h0);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int d = 0; d < 3; d++) begin
      hits[d] = 0; em[d] = 1'b0; ep[d] = 1'b0; ewv[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic sh, input logic b, input logic clr);
    if (clr) begin
      model_reset();
    end else if (sh) begin
      hist.push_back(b);
      for (int d = 0; d < 3; d++) begin
        em[d]  = hit_of(d);
        ep[d]  = em[d];
        if (em[d]) hits[d]++;
        ewv[d] = ((hist.size() % w_of(d)) == 0);
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        ep[d] = 1'b0; ewv[d] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_dut(input int d, input logic [7:0] par, input logic pr, input logic m,
                           input logic mp, input logic wv, input logic [7:0] cnt);
    int c;
    c = (hits[d] > cap_of(d)) ? cap_of(d) : hits[d];
    check($sformatf("d%0d_par", d), par, par_of(d));
    check($sformatf("d%0d_primed", d), pr, hist.size() >= w_of(d));
    check($sformatf("d%0d_match", d), m, em[d]);
    check($sformatf("d%0d_pulse", d), mp, ep[d]);
    check($sformatf("d%0d_wv", d), wv, ewv[d]);
    check($sformatf("d%0d_cnt", d), cnt, c);
  endtask

  task automatic check_all();
    check_dut(0, {4'b0, par_a}, primed_a, match_a, pulse_a, wv_a, cnt_a);
    check_dut(1, {4'b0, par_b}, primed_b, match_b, pulse_b, wv_b, {6'b0, cnt_b});
    check_dut(2, {3'b0, par_c}, primed_c, match_c, pulse_c, wv_c, {5'b0, cnt_c});
  endtask

  task automatic step(input logic sh, input logic b, input logic clr);
    @(negedge clk);
    shift_en = sh; ser_in = b; clear = clr;
    @(posedge clk);
    model_edge(sh, b, clr);
    #1;
    check_all();
  endtask

  task automatic shift_bits(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0);
  endtask

  // Reset asserted and released between clock edges.
  task automatic pulse_rst();
    @(negedge clk);
    shift_en = 1'b0; clear = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single match, then overlapping match on pattern 1101.
    pattern_r = 5'b01101; mask_r = 5'b11111;
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
    for (int i = 0; i < 7; i++) begin
      logic [6:0] s;
      s = 7'b1101101;
      step(1'b1, s[6-i], 1'b0);
      check("overlap_cnt", cnt_a, exp_q.pop_front());
    end
    check("overlap_par", par_a, 4'b1101);

    // Priming with an all-zero pattern.
    step(1'b0, 1'b0, 1'b1);
    pattern_r = 5'b00000;
    shift_bits(16'h0000, 3);
    check("prime_match3", match_a, 1'b0);
    shift_bits(16'h0000, 1);
    check("prime_cnt4", cnt_a, 8'd1);

    // Saturation with everything masked off.
    step(1'b0, 1'b0, 1'b1);
    mask_r = 5'b00000;
    shift_bits(16'h00A5, 8);
    check("sat_cnt_b", cnt_b, 2'd3);

    // LSB-first loading, then clear beating a shift.
    step(1'b0, 1'b0, 1'b1);
    mask_r = 5'b11111;
    shift_bits(16'b1000, 4);
    check("lsb_par_c", par_c, 5'b00010);
    step(1'b1, 1'b1, 1'b1);
    check("clr_par_a", par_a, 4'b0000);

    // Reset in the middle of a frame.
    shift_bits(16'b101, 3);
    pulse_rst();
    check("rst_par_a", par_a, 4'b0000);
    shift_bits(16'b1011, 4);
    check("rst_wv_a", wv_a, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        pattern_r = 5'($urandom);
        mask_r    = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom);
      end
      if ($urandom_range(0, 60) == 0) pulse_rst();
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
